// File: rtl/alu_defs_pkg.sv
// rtl/alu_defs_pkg.sv - shared ALU/writeback constants, opcode enums and the write-queue entry type
package alu_defs_pkg;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int DEPTH  = 2;

  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  typedef enum logic [3:0] {
    OP_RTYPE = 4'h0,
    OP_ANDI  = 4'h1,
    OP_ORI   = 4'h2,
    OP_XORI  = 4'h3,
    OP_BCOND = 4'h4,
    OP_ADDI  = 4'h5,
    OP_SHIFT = 4'h8,
    OP_SUBI  = 4'h9,
    OP_CMPI  = 4'hB,
    OP_MOVI  = 4'hD
  } opcode_t;

  typedef enum logic [3:0] {
    FN_AND = 4'h1,
    FN_OR  = 4'h2,
    FN_XOR = 4'h3,
    FN_ADD = 4'h5,
    FN_SUB = 4'h9,
    FN_CMP = 4'hB,
    FN_MOV = 4'hD
  } func_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_HI = 4'h4,
    COND_LS = 4'h5,
    COND_GT = 4'h6,
    COND_LE = 4'h7,
    COND_FS = 4'h8,
    COND_FC = 4'h9,
    COND_UC = 4'hE
  } cond_t;

  typedef struct packed {
    logic [REG_AW-1:0] reg_addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - 2-entry in-order register-write queue with count and registered head outputs
module wb_queue
  import alu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [REG_AW-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [1:0]        o_count,
  output logic [REG_AW-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data
);

  logic [1:0] r_count;
  wb_entry_t  r_head;
  wb_entry_t  r_tail;
  wb_entry_t  w_in;
  logic       w_push;
  logic       w_pop;

  assign w_in   = '{reg_addr: i_push_addr, data: i_push_data};
  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & (r_count != 2'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_in;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          // Push with pop in ONE replaces the head directly; the count is unchanged.
          if (w_push) begin
            if (w_pop) begin
              r_head <= w_in;
            end else begin
              r_tail  <= w_in;
              r_count <= 2'd2;
            end
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_head  <= r_tail;
            r_count <= 2'd1;
          end
        end
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_head_addr = r_head.reg_addr;
  assign o_head_data = r_head.data;

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU writeback stage: PSR commit, buffered RF writes, retire counter
// Optional PSR_BYPASS_EN forwards the accepted flag update onto psrRead in the same cycle.
module alu_writeback
  import alu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic              inRegWr,
  input  logic [REG_AW-1:0] inDstReg,
  input  logic [DATA_W-1:0] result,
  input  logic [4:0]        psrWrite,
  input  logic [4:0]        psrWrEn,
  output logic [4:0]        psrRead,
  output logic              rfWrEn,
  output logic [REG_AW-1:0] rfAddr,
  output logic [DATA_W-1:0] rfData,
  input  logic              rfReady,
  output logic [15:0]       retired
);

  logic [4:0]  r_psr;
  logic [15:0] r_retired;
  logic [1:0]  w_count;
  logic        w_accept;
  logic [4:0]  w_psr_next;

  // inReady depends only on the registered queue count, never on inValid.
  assign inReady    = (w_count != 2'(DEPTH));
  assign w_accept   = inValid & inReady;
  assign w_psr_next = (r_psr & ~psrWrEn) | (psrWrite & psrWrEn);
  assign rfWrEn     = (w_count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_psr     <= 5'b0;
      r_retired <= 16'd0;
    end else if (w_accept) begin
      r_psr     <= w_psr_next;
      r_retired <= r_retired + 16'd1;
    end
  end

`ifdef PSR_BYPASS_EN
  assign psrRead = w_accept ? w_psr_next : r_psr;
`else
  assign psrRead = r_psr;
`endif

  assign retired = r_retired;

  wb_queue u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_accept & inRegWr),
    .i_push_addr (inDstReg),
    .i_push_data (result),
    .i_pop       (rfWrEn & rfReady),
    .o_count     (w_count),
    .o_head_addr (rfAddr),
    .o_head_data (rfData)
  );

endmodule
